// File: rtl/pattern_match_if.sv
// Control, configuration and status bundle for the serial pattern matcher.
// The master drives requests, configuration and data; the slave reports status.
interface pattern_match_if #(
  parameter int PW = 8,
  parameter int CW = 8
);
  logic          start;
  logic          abort;
  logic [PW-1:0] cfg_pattern;
  logic [3:0]    cfg_len;
  logic          cfg_overlap;
  logic [CW-1:0] cfg_target;
  logic          x;
  logic          x_valid;
  logic          busy;
  logic          z;
  logic          done;
  logic          err;
  logic [CW-1:0] match_cnt;

  modport master (
    output start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_target, x, x_valid,
    input  busy, z, done, err, match_cnt
  );

  modport slave (
    input  start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_target, x, x_valid,
    output busy, z, done, err, match_cnt
  );
endinterface

// File: rtl/pattern_match_ctrl.sv
// Serial bit-pattern detector with IDLE/RUN/DONE control, overlap selection,
// saturating match counter and an optional target count that ends the run.
module pattern_match_ctrl #(
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           reset,
  pattern_match_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // cfg_len is 4 bits wide, so PW is assumed to be at most 15
  localparam logic [3:0] PW_L = 4'(PW);

  state_t        state_q, state_nxt;
  logic [PW-1:0] hist_q, hist_nxt, hist_sh;
  logic [PW-1:0] pat_q, pat_nxt, mask;
  logic [3:0]    fill_q, fill_nxt, fill_inc;
  logic [3:0]    len_q, len_nxt;
  logic          ovl_q, ovl_nxt;
  logic [CW-1:0] tgt_q, tgt_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt, cnt_inc;
  logic          z_q, z_nxt, done_q, done_nxt, err_q, err_nxt;
  logic          len_ok, match;

  function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [3:0] sat_inc_fill(input logic [3:0] v);
    return (v >= PW_L) ? PW_L : v + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    len_ok   = (bus.cfg_len != 4'd0) && (bus.cfg_len <= PW_L);
    hist_sh  = {hist_q[PW-2:0], bus.x};
    fill_inc = sat_inc_fill(fill_q);
    mask     = ~({PW{1'b1}} << len_q);
    match    = (state_q == RUN) && bus.x_valid && (fill_inc >= len_q) &&
               ((hist_sh & mask) == (pat_q & mask));
    cnt_inc  = sat_inc_cnt(cnt_q);

    state_nxt = state_q;
    hist_nxt  = hist_q;
    fill_nxt  = fill_q;
    pat_nxt   = pat_q;
    len_nxt   = len_q;
    ovl_nxt   = ovl_q;
    tgt_nxt   = tgt_q;
    cnt_nxt   = cnt_q;
    z_nxt     = match;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (len_ok) begin
            pat_nxt   = bus.cfg_pattern;
            len_nxt   = bus.cfg_len;
            ovl_nxt   = bus.cfg_overlap;
            tgt_nxt   = bus.cfg_target;
            hist_nxt  = '0;
            fill_nxt  = 4'd0;
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.x_valid) begin
          hist_nxt = hist_sh;
          fill_nxt = fill_inc;
        end
        // Non-overlapping mode demands a full fresh window after each hit
        if (match) begin
          cnt_nxt = cnt_inc;
          if (!ovl_q) fill_nxt = 4'd0;
        end
        if (bus.abort)
          state_nxt = IDLE;
        else if (match && (tgt_q != '0) && (cnt_inc == tgt_q))
          state_nxt = DONE;
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= 4'd0;
      pat_q  <= '0;
      len_q  <= 4'd0;
      ovl_q  <= 1'b0;
      tgt_q  <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_nxt;
      fill_q <= fill_nxt;
      pat_q  <= pat_nxt;
      len_q  <= len_nxt;
      ovl_q  <= ovl_nxt;
      tgt_q  <= tgt_nxt;
      cnt_q  <= cnt_nxt;
      z_q    <= z_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.z         = z_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Directed bench for pattern_match_ctrl: a queue-based reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_pattern_match_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en = 1'b0;

  pattern_match_if #(.PW(8), .CW(8)) bus ();

  pattern_match_ctrl #(.PW(8), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of the valid bits seen since the run began (or since
  // the last non-overlapping hit), compared against the pattern tail.
  bit         mq[$];
  int         m_phase = 0;
  logic       m_busy = 0, m_z = 0, m_done = 0, m_err = 0;
  logic [7:0] m_cnt = 0;
  logic [7:0] m_pat = 0;
  int         m_len = 0;
  bit         m_ovl = 0;
  int         m_tgt = 0;

  always @(posedge clk) begin
    bit nz, nd, ne, hit;
    nz = 0; nd = 0; ne = 0; hit = 0;
    if (reset) begin
      m_phase = 0; m_cnt = 0; m_pat = 0; m_len = 0; m_ovl = 0; m_tgt = 0;
      mq.delete();
    end else begin
      case (m_phase)
        0: if (bus.start && !bus.abort) begin
             if (bus.cfg_len >= 1 && bus.cfg_len <= 8) begin
               m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len);
               m_ovl = bus.cfg_overlap; m_tgt = int'(bus.cfg_target);
               mq.delete(); m_cnt = 0; m_phase = 1;
             end else ne = 1;
           end
        1: begin
             if (bus.x_valid) begin
               mq.push_back(bus.x);
               if (mq.size() > 8) void'(mq.pop_front());
               if (mq.size() >= m_len) begin
                 hit = 1;
                 for (int i = 0; i < m_len; i++)
                   if (mq[mq.size()-1-i] != m_pat[i]) hit = 0;
               end
             end
             if (hit) begin
               nz = 1;
               if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
               if (!m_ovl) mq.delete();
             end
             if (bus.abort) m_phase = 0;
             else if (hit && m_tgt != 0 && int'(m_cnt) == m_tgt) m_phase = 2;
           end
        default: begin nd = 1; m_phase = 0; end
      endcase
    end
    m_z = nz; m_done = nd; m_err = ne; m_busy = (m_phase == 1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", bus.busy, m_busy);
      chk("model_z", bus.z, m_z);
      chk("model_done", bus.done, m_done);
      chk("model_err", bus.err, m_err);
      chk("model_cnt", bus.match_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic arm(input logic [7:0] pat, input logic [3:0] len, input bit ovl, input logic [7:0] tgt);
    bus.cfg_pattern = pat; bus.cfg_len = len; bus.cfg_overlap = ovl; bus.cfg_target = tgt;
    bus.start = 1; tick(); bus.start = 0;
  endtask

  task automatic send(input bit b);
    bus.x = b; bus.x_valid = 1; tick(); bus.x_valid = 0;
  endtask

  task automatic do_abort();
    bus.abort = 1; tick(); bus.abort = 0;
  endtask

  bit         seq[7] = '{1, 0, 1, 1, 0, 1, 1};
  logic [6:0] zs;

  initial begin
    reset = 1;
    bus.start = 0; bus.abort = 0; bus.cfg_pattern = 0; bus.cfg_len = 0;
    bus.cfg_overlap = 0; bus.cfg_target = 0; bus.x = 0; bus.x_valid = 0;
    tick(); tick();
    chk_en = 1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_z", bus.z, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_cnt", bus.match_cnt, 0);
    reset = 0;

    // Overlapping, no target
    arm(8'b1011, 4'd4, 1, 8'd0);
    chk("ovl_busy_arm", bus.busy, 1);
    zs = '0;
    for (int i = 0; i < 7; i++) begin send(seq[i]); zs[i] = bus.z; end
    chk("ovl_z_positions", 32'(zs), 32'b1001000);
    chk("ovl_cnt", bus.match_cnt, 2);
    chk("ovl_busy", bus.busy, 1);
    do_abort();

    // Non-overlapping
    arm(8'b1011, 4'd4, 0, 8'd0);
    zs = '0;
    for (int i = 0; i < 7; i++) begin send(seq[i]); zs[i] = bus.z; end
    chk("novl_z_positions", 32'(zs), 32'b0001000);
    chk("novl_cnt", bus.match_cnt, 1);
    do_abort();

    // Target of two
    arm(8'b1011, 4'd4, 1, 8'd2);
    for (int i = 0; i < 7; i++) send(seq[i]);
    chk("tgt_z_last", bus.z, 1);
    chk("tgt_done_early", bus.done, 0);
    tick();
    chk("tgt_done", bus.done, 1);
    chk("tgt_busy", bus.busy, 0);
    tick();
    chk("tgt_done_once", bus.done, 0);
    chk("tgt_cnt", bus.match_cnt, 2);

    // Illegal lengths
    bus.cfg_len = 4'd0; bus.start = 1; tick(); bus.start = 0;
    chk("err_len0", bus.err, 1);
    chk("err_len0_busy", bus.busy, 0);
    tick();
    chk("err_len0_once", bus.err, 0);
    bus.cfg_len = 4'd9; bus.start = 1; tick(); bus.start = 0;
    chk("err_len9", bus.err, 1);
    chk("err_len9_busy", bus.busy, 0);
    chk("err_cnt_kept", bus.match_cnt, 2);
    tick();

    // start together with abort is ignored
    bus.cfg_len = 4'd0; bus.start = 1; bus.abort = 1; tick(); bus.start = 0; bus.abort = 0;
    chk("abort_start_err", bus.err, 0);
    chk("abort_start_busy", bus.busy, 0);

    // Abort after three bits
    arm(8'b1011, 4'd4, 1, 8'd0);
    send(1); send(0); send(1);
    do_abort();
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_cnt", bus.match_cnt, 0);
    tick();

    // Abort on the same edge as a match
    arm(8'b1011, 4'd4, 1, 8'd0);
    send(1); send(0); send(1);
    bus.x = 1; bus.x_valid = 1; bus.abort = 1; tick(); bus.x_valid = 0; bus.abort = 0;
    chk("abort_match_z", bus.z, 1);
    chk("abort_match_busy", bus.busy, 0);
    chk("abort_match_cnt", bus.match_cnt, 1);

    // Reset mid-run, then start on the first edge afterwards
    arm(8'b1011, 4'd4, 1, 8'd0);
    send(1); send(0);
    reset = 1; tick(); reset = 0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_cnt", bus.match_cnt, 0);
    chk("mid_rst_z", bus.z, 0);
    arm(8'b1011, 4'd4, 1, 8'd0);
    chk("post_rst_busy", bus.busy, 1);
    send(1); send(0); send(1); send(1);
    chk("post_rst_z", bus.z, 1);
    chk("post_rst_cnt", bus.match_cnt, 1);
    do_abort();

    // Gaps in x_valid
    arm(8'b1011, 4'd4, 1, 8'd0);
    send(1); send(0);
    for (int i = 0; i < 5; i++) begin bus.x = i[0]; bus.x_valid = 0; tick(); end
    send(1);
    chk("gap_z_early", bus.z, 0);
    send(1);
    chk("gap_z", bus.z, 1);
    chk("gap_cnt", bus.match_cnt, 1);
    do_abort();

    // Counter saturation
    arm(8'b1, 4'd1, 1, 8'd0);
    for (int i = 0; i < 260; i++) send(1);
    chk("sat_cnt", bus.match_cnt, 255);
    chk("sat_busy", bus.busy, 1);
    do_abort();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_match_ctrl.md
PATTERN_MATCH_CTRL -- requirements
Module: pattern_match_ctrl

Interface
REQ-001 SHALL have parameter PW, default 8: maximum pattern width in bits.
REQ-002 SHALL have parameter CW, default 8: match counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to arm a detection run.
REQ-006 SHALL have port abort, input, 1 bit: terminates a run.
REQ-007 SHALL have port cfg_pattern, input, PW bits: pattern; bit cfg_len-1 is the oldest bit, bit 0 the newest.
REQ-008 SHALL have port cfg_len, input, 4 bits: pattern length; legal range 1..PW.
REQ-009 SHALL have port cfg_overlap, input, 1 bit: 1 selects overlapping detection, 0 non-overlapping.
REQ-010 SHALL have port cfg_target, input, CW bits: match count that ends the run; 0 means run until abort.
REQ-011 SHALL have port x, input, 1 bit: serial data bit.
REQ-012 SHALL have port x_valid, input, 1 bit: x is sampled only when high.
REQ-013 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-014 SHALL have port z, output, 1 bit: registered one-cycle match pulse.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when the target is reached.
REQ-016 SHALL have port err, output, 1 bit: one-cycle pulse when start is rejected.
REQ-017 SHALL have port match_cnt, output, CW bits: matches counted in the current or last run.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE, all as registered state.
REQ-019 IDLE with start=1, abort=0 and 1<=cfg_len<=PW SHALL latch cfg_*, clear the history shift register, fill counter and match_cnt, and enter RUN the next cycle.
REQ-020 IDLE with start=1 and cfg_len=0 or cfg_len>PW SHALL pulse err for one cycle and stay in IDLE; match_cnt SHALL be unchanged.
REQ-021 start SHALL be ignored in RUN and DONE; the latched configuration SHALL NOT change during a run.
REQ-022 In RUN, each edge with x_valid=1 SHALL shift x into history bit 0 and increment fill (saturating at PW); x_valid=0 SHALL leave history and fill unchanged.
REQ-023 A match SHALL occur on the shifting edge when fill (after the increment) >= len and history[len-1:0] (including the new bit) equals pattern[len-1:0].
REQ-024 On a match: z=1 for exactly the following cycle; match_cnt increments on the same edge, saturating at 2^CW-1.
REQ-025 Overlapping mode SHALL keep history and fill after a match; non-overlapping mode SHALL reset fill to 0 on a match.
REQ-026 When a match makes match_cnt equal a nonzero target, the FSM SHALL enter DONE; DONE SHALL assert done for one cycle, then return to IDLE with busy=0.
REQ-027 abort=1 in RUN SHALL return to IDLE on the next edge with no done pulse; match_cnt SHALL hold its value; a match on the same edge SHALL still pulse z and count.
REQ-028 abort=1 together with start in IDLE SHALL ignore start, with no err pulse.
REQ-029 busy SHALL equal 1 only in RUN; z, done and err SHALL never be high for two consecutive cycles.

Reset
REQ-030 reset=1 at a clk edge SHALL force IDLE and clear history, fill, latched configuration, match_cnt, busy, z, done and err to 0, overriding every other input, including mid-run.
REQ-031 After reset deasserts, the block SHALL accept start on the first edge.

Verification
REQ-032 pattern=4'b1011, len=4, overlap=1, target=0; x=1,0,1,1,0,1,1 with valid high -> z pulses after the 4th and 7th bits; match_cnt=2; busy stays 1.
REQ-033 Same stimulus with overlap=0 -> z pulses after the 4th bit only; match_cnt=1.
REQ-034 Overlap=1, target=2, same stimulus -> done pulses once, the cycle after the second z; then busy=0 and match_cnt=2.
REQ-035 start with cfg_len=0, then with cfg_len=9 (PW=8) -> err pulses each time; busy stays 0.
REQ-036 abort after 3 bits -> busy=0 next cycle with no done; reset mid-run -> all outputs 0, and a following start arms a fresh run.
REQ-037 x_valid low for 5 cycles inside the sequence 1,0,1,1 -> the match is still detected, on the edge of the final valid bit.
